wb_drv_sweep_ctrl: RTL and testbench
====================================

Name: wb_drv_sweep_ctrl

Overview:
- Wishbone master that sequences calibration sweeps of the LVDS driver configuration slave (delay sync / delay p / delay n / current registers at BASE_ADDR+0..3).
- On start, writes a series of thermometer-coded settings to one selected register, from a first step to a last step.
- Holds each setting for a programmable dwell time, then advances to the next step.
- Flags each settled step so external measurement logic can sample it, and reports done or bus error.

Parameters:
- BASE_ADDR, 32'h0300_0000, word address of config register 0; register n is at BASE_ADDR+n.
- DWELL_W, 16, width of the dwell counter.
- ACK_TIMEOUT, 15, cycles allowed from stb acceptance to ack before the error path is taken.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start request; ignored while o_busy=1.
- i_abort  in  1  level; request to stop the sweep.
- i_sel  in  2  target register index (0 sync, 1 p, 2 n, 3 current); latched at start.
- i_first  in  5  first step (0..16); latched at start.
- i_last  in  5  last step (0..16); latched at start.
- i_dwell  in  DWELL_W  hold cycles per step; latched at start.
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe.
- o_wb_we  out  1  write enable; always 1 while o_wb_cyc=1, else 0.
- o_wb_addr  out  32  BASE_ADDR + sel.
- o_wb_data  out  32  {~therm(step), therm(step)}.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_stall  in  1  slave stall.
- o_busy  out  1  sweep in progress.
- o_step  out  5  current step.
- o_step_valid  out  1  one-cycle pulse when a step's write has been acked.
- o_done  out  1  one-cycle pulse on normal completion.
- o_error  out  1  sticky ack-timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (async assert, sync release): FSM to IDLE; all outputs 0 (o_wb_addr and o_wb_data 0); counters 0.
- Thermometer coding: therm(n) is a 16-bit value with bits [n-1:0] set; therm(0)=0, therm(16)=16'hFFFF.
- Input clamp: i_first and i_last values above 16 are clamped to 16 when latched.
- Sweep direction: increment when first<=last, else decrement. first==last gives a single step.
- FSM states: IDLE, REQ, WACK, DWELL, DONE.
- IDLE: on i_start, latch sel/first/last/dwell, set step=first, set o_busy=1, clear o_error, go to REQ. cyc, stb, addr and data are valid on the cycle after start.
- REQ: hold cyc=1, stb=1 and stable addr/data while i_wb_stall=1. On the edge where stall=0, go to WACK with stb=0, cyc=1, and the timeout counter cleared.
- Ack in the acceptance cycle: if i_wb_ack=1 in the same cycle the request is accepted, treat it as the ack and go directly to DWELL.
- WACK: on i_wb_ack, set cyc=0, pulse o_step_valid for one cycle, load the dwell counter with dwell, go to DWELL.
- Ack timeout: ACK_TIMEOUT cycles in WACK with no ack sets cyc=0, o_error=1 and o_busy=0, and returns to IDLE with no o_done.
- DWELL: decrement the counter. At 0, if step==last go to DONE; otherwise step moves by ±1 and the FSM goes to REQ. Dwell=0 goes to REQ (or DONE) on the cycle after the ack.
- DONE: o_done=1 and o_busy=0 for one cycle, then IDLE.
- o_step holds its last value in IDLE.
- Abort in IDLE or DWELL: IDLE on the next edge, o_busy=0, no o_done.
- Abort in REQ or WACK: finish the bus transaction first (ack or timeout), then IDLE; no o_step_valid for the aborted step.
- Wishbone rules: stb is never asserted without cyc. Only one transaction is outstanding at a time. An ack outside WACK or the acceptance cycle is ignored.
- Start during the DONE cycle is ignored.
- Reset mid-transaction drops cyc/stb immediately.

Test Plan:
- Up-sweep: sel=1, first=0, last=3, dwell=2, zero-wait slave acking one cycle after acceptance -> 4 writes to 0x0300_0001 with data 0xFFFF_0000, 0xFFFE_0001, 0xFFFC_0003, 0xFFF8_0007; 4 o_step_valid pulses 5 cycles apart; single o_done; o_busy low on the o_done cycle.
- Down-sweep with clamp: sel=0, first=20, last=15, dwell=0 -> writes with data 0x0000_FFFF then 0x8000_7FFF to 0x0300_0000; o_step ends at 15.
- Stall: slave stalls 3 cycles on the first request -> stb/addr/data stable for 4 cycles, exactly one write, sweep then proceeds normally.
- Ack timeout: slave never acks -> cyc drops 15 cycles after acceptance, o_error=1, no o_done; next start clears o_error.
- Abort: abort during dwell of step 1 (first=0, last=5) -> IDLE next cycle, no o_done, no further bus activity. Abort during WACK -> ack honoured, cyc drops, IDLE without o_step_valid.
- Reset: assert reset during REQ -> cyc, stb, busy and all outputs 0 asynchronously; start after release works normally; start while busy -> ignored.

Source files
------------

// File: rtl/wb_drv_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// wb_drv_sweep_ctrl
//
// Wishbone master that runs calibration sweeps over one register of the LVDS
// driver configuration slave. A start request latches the target register,
// the first and last thermometer step and a dwell time. Each step is written
// as {~therm(step), therm(step)}, held for the dwell time, then the step
// moves one position toward the last step. Every acked step is flagged with
// a one-cycle o_step_valid pulse so measurement logic can sample it.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   i_start      one-cycle start request, ignored while busy
//   i_abort      level, stops the sweep (bus transaction is finished first)
//   i_sel        target register index, latched at start
//   i_first      first step 0..16 (larger values clamp to 16), latched at start
//   i_last       last step 0..16 (larger values clamp to 16), latched at start
//   i_dwell      hold cycles per step, latched at start
//   o_wb_cyc     Wishbone cycle
//   o_wb_stb     Wishbone strobe
//   o_wb_we      write enable, follows o_wb_cyc
//   o_wb_addr    BASE_ADDR + sel while cyc is high, else 0
//   o_wb_data    {~therm(step), therm(step)} while cyc is high, else 0
//   i_wb_ack     slave acknowledge
//   i_wb_stall   slave stall
//   o_busy       sweep in progress
//   o_step       current step, holds its last value when idle
//   o_step_valid one-cycle pulse after a step's write is acked
//   o_done       one-cycle pulse on normal completion
//   o_error      sticky ack-timeout flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module wb_drv_sweep_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          DWELL_W     = 16,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [1:0]         i_sel,
  input  logic [4:0]         i_first,
  input  logic [4:0]         i_last,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  output logic               o_wb_we,
  output logic [31:0]        o_wb_addr,
  output logic [31:0]        o_wb_data,
  input  logic               i_wb_ack,
  input  logic               i_wb_stall,
  output logic               o_busy,
  output logic [4:0]         o_step,
  output logic               o_step_valid,
  output logic               o_done,
  output logic               o_error
);

  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WACK,
    S_DWELL,
    S_DONE
  } state_t;

  state_t             state, state_n;

  logic [1:0]         sel_r;
  logic [4:0]         step_r;
  logic [4:0]         last_r;
  logic               up_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               abort_pend;
  logic               valid_r;
  logic               error_r;

  logic               load_cfg;
  logic               load_dwell;
  logic               set_valid;
  logic               set_error;
  logic               set_pend;
  logic               advance;
  logic               tmo_clr;
  logic               tmo_inc;
  logic               dwell_dec;
  logic               bus_active;

  logic [4:0]         first_c;
  logic [4:0]         last_c;

  function automatic logic [4:0] clamp16(input logic [4:0] v);
    return (v > 5'd16) ? 5'd16 : v;
  endfunction

  // therm(n) has bits [n-1:0] set; computed in 17 bits so n=16 gives 16'hFFFF
  function automatic logic [15:0] therm(input logic [4:0] n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  assign first_c = clamp16(i_first);
  assign last_c  = clamp16(i_last);

  // State register; async reset drops cyc/stb immediately since the bus
  // outputs are decoded from the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic, datapath control strobes and decoded outputs.
  // An abort seen in REQ/WACK is remembered so the transaction completes
  // (ack or timeout) before returning to IDLE without reporting the step.
  always_comb begin
    state_n    = state;
    load_cfg   = 1'b0;
    load_dwell = 1'b0;
    set_valid  = 1'b0;
    set_error  = 1'b0;
    set_pend   = 1'b0;
    advance    = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    dwell_dec  = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          load_cfg = 1'b1;
          state_n  = S_REQ;
        end
      end

      S_REQ: begin
        set_pend = i_abort;
        if (!i_wb_stall) begin
          if (i_wb_ack) begin
            // ack in the acceptance cycle counts as the transaction's ack
            if (abort_pend || i_abort) begin
              state_n = S_IDLE;
            end else begin
              set_valid  = 1'b1;
              load_dwell = 1'b1;
              state_n    = S_DWELL;
            end
          end else begin
            tmo_clr = 1'b1;
            state_n = S_WACK;
          end
        end
      end

      S_WACK: begin
        set_pend = i_abort;
        if (i_wb_ack) begin
          if (abort_pend || i_abort) begin
            state_n = S_IDLE;
          end else begin
            set_valid  = 1'b1;
            load_dwell = 1'b1;
            state_n    = S_DWELL;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          set_error = 1'b1;
          state_n   = S_IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      S_DWELL: begin
        if (i_abort) begin
          state_n = S_IDLE;
        end else if (dwell_cnt == '0) begin
          if (step_r == last_r) begin
            state_n = S_DONE;
          end else begin
            advance = 1'b1;
            state_n = S_REQ;
          end
        end else begin
          dwell_dec = 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    bus_active   = (state == S_REQ) || (state == S_WACK);
    o_wb_cyc     = bus_active;
    o_wb_stb     = (state == S_REQ);
    o_wb_we      = bus_active;
    o_wb_addr    = 32'd0;
    o_wb_data    = 32'd0;
    if (bus_active) begin
      o_wb_addr = BASE_ADDR + {30'd0, sel_r};
      o_wb_data = {~therm(step_r), therm(step_r)};
    end
    o_busy       = bus_active || (state == S_DWELL);
    o_done       = (state == S_DONE);
    o_step       = step_r;
    o_step_valid = valid_r;
    o_error      = error_r;
  end

  // Sweep configuration, step, dwell/timeout counters and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r      <= 2'd0;
      step_r     <= 5'd0;
      last_r     <= 5'd0;
      up_r       <= 1'b0;
      dwell_r    <= '0;
      dwell_cnt  <= '0;
      tmo_cnt    <= '0;
      abort_pend <= 1'b0;
      valid_r    <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      valid_r <= set_valid;

      if (load_cfg) begin
        sel_r      <= i_sel;
        step_r     <= first_c;
        last_r     <= last_c;
        up_r       <= (first_c <= last_c);
        dwell_r    <= i_dwell;
        error_r    <= 1'b0;
        abort_pend <= 1'b0;
      end else begin
        if (set_pend) begin
          abort_pend <= 1'b1;
        end
        if (set_error) begin
          error_r <= 1'b1;
        end
        if (advance) begin
          step_r <= up_r ? (step_r + 5'd1) : (step_r - 5'd1);
        end
      end

      if (load_dwell) begin
        dwell_cnt <= dwell_r;
      end else if (dwell_dec) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end

      if (tmo_clr) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_drv_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_drv_sweep_ctrl
//
// Bench for wb_drv_sweep_ctrl: a simple Wishbone slave model answers the
// master's requests, a monitor logs writes and pulses, and directed sweeps
// are compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_wb_drv_sweep_ctrl;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic        i_abort;
  logic [1:0]  i_sel;
  logic [4:0]  i_first;
  logic [4:0]  i_last;
  logic [15:0] i_dwell;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic        wb_ack;
  logic        wb_stall;
  logic        o_busy;
  logic [4:0]  o_step;
  logic        o_step_valid;
  logic        o_done;
  logic        o_error;

  wb_drv_sweep_ctrl #(
    .BASE_ADDR  (32'h0300_0000),
    .DWELL_W    (16),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_sel       (i_sel),
    .i_first     (i_first),
    .i_last      (i_last),
    .i_dwell     (i_dwell),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_addr   (o_wb_addr),
    .o_wb_data   (o_wb_data),
    .i_wb_ack    (wb_ack),
    .i_wb_stall  (wb_stall),
    .o_busy      (o_busy),
    .o_step      (o_step),
    .o_step_valid(o_step_valid),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [15:0] dwell;
    bit          ack_same;
    int          writes;
    logic [31:0] addr;
    logic [31:0] data_first;
    logic [31:0] data_last;
    logic [4:0]  step;
    int          gap;
  } vec_t;

  vec_t vecs[5];

  int n_checks = 0;
  int n_fail   = 0;

  // slave behaviour knobs
  int stall_left = 0;
  int ack_delay  = 1;
  bit never_ack  = 1'b0;
  bit ack_same   = 1'b0;
  int wait_cnt   = 0;

  // monitor statistics
  int          cycle = 0;
  int          sv_cnt;
  int          done_cnt;
  int          wack_cycles;
  int          stb_cycles;
  int          unstable;
  int          proto_err;
  int          last_sv;
  int          min_gap;
  int          max_gap;
  int          gap_now;
  logic        prev_stb;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  // Slave model and monitor share one process so the write log and the
  // stall/ack decisions for a cycle are always consistent.
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (!reset) begin
      wb_ack   = 1'b0;
      wb_stall = 1'b0;
      wait_cnt = 0;
      prev_stb = 1'b0;
    end else begin
      if (o_wb_stb && !o_wb_cyc) proto_err = proto_err + 1;
      if (o_wb_we != o_wb_cyc) proto_err = proto_err + 1;
      if (o_done && o_busy) proto_err = proto_err + 1;
      if (o_step_valid) begin
        sv_cnt = sv_cnt + 1;
        if (last_sv >= 0) begin
          gap_now = cycle - last_sv;
          if (gap_now < min_gap) min_gap = gap_now;
          if (gap_now > max_gap) max_gap = gap_now;
        end
        last_sv = cycle;
      end
      if (o_done) done_cnt = done_cnt + 1;
      if (o_wb_cyc && !o_wb_stb) wack_cycles = wack_cycles + 1;
      if (o_wb_stb) begin
        stb_cycles = stb_cycles + 1;
        if (prev_stb && (o_wb_addr != prev_addr || o_wb_data != prev_data))
          unstable = unstable + 1;
      end
      prev_stb  = o_wb_stb;
      prev_addr = o_wb_addr;
      prev_data = o_wb_data;

      wb_ack = 1'b0;
      if (wait_cnt == 1) begin
        wb_ack   = 1'b1;
        wait_cnt = 0;
      end else if (wait_cnt > 1) begin
        wait_cnt = wait_cnt - 1;
      end
      wb_stall = 1'b0;
      if (o_wb_stb) begin
        if (stall_left > 0) begin
          wb_stall   = 1'b1;
          stall_left = stall_left - 1;
        end else begin
          wr_addr.push_back(o_wb_addr);
          wr_data.push_back(o_wb_data);
          if (ack_same) wb_ack = 1'b1;
          else if (!never_ack) wait_cnt = ack_delay;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    sv_cnt      = 0;
    done_cnt    = 0;
    wack_cycles = 0;
    stb_cycles  = 0;
    unstable    = 0;
    proto_err   = 0;
    last_sv     = -1;
    min_gap     = 1000;
    max_gap     = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  function automatic logic [31:0] firstData();
    return (wr_data.size() > 0) ? wr_data[0] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lastData();
    return (wr_data.size() > 0) ? wr_data[wr_data.size()-1] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lastAddr();
    return (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : 32'hDEAD_BEEF;
  endfunction

  // Pulse start for one cycle; returns at the falling edge of the first REQ cycle.
  task automatic startSweep(input logic [1:0] sel, input logic [4:0] first,
                            input logic [4:0] last, input logic [15:0] dwell);
    @(negedge clk);
    i_sel   = sel;
    i_first = first;
    i_last  = last;
    i_dwell = dwell;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        idle = 1'b1;
        break;
      end
    end
    checkOutput({name, " reaches idle"}, {31'd0, idle}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] sel,
                               input logic [4:0] first, input logic [4:0] last,
                               input logic [15:0] dwell);
    startSweep(sel, first, last, dwell);
    waitIdle(name);
  endtask

  initial begin
    bit found;

    // sel, first, last, dwell, ack_same, writes, addr, first data, last data, final step, step_valid gap
    vecs[0] = '{2'd1, 5'd0,  5'd3,  16'd2, 1'b0, 4, 32'h0300_0001, 32'hFFFF_0000, 32'hFFF8_0007, 5'd3,  5};
    vecs[1] = '{2'd0, 5'd20, 5'd15, 16'd0, 1'b0, 2, 32'h0300_0000, 32'h0000_FFFF, 32'h8000_7FFF, 5'd15, 3};
    vecs[2] = '{2'd3, 5'd7,  5'd7,  16'd1, 1'b0, 1, 32'h0300_0003, 32'hFF80_007F, 32'hFF80_007F, 5'd7,  0};
    vecs[3] = '{2'd2, 5'd2,  5'd0,  16'd3, 1'b1, 3, 32'h0300_0002, 32'hFFFC_0003, 32'hFFFF_0000, 5'd0,  5};
    vecs[4] = '{2'd1, 5'd16, 5'd31, 16'd0, 1'b0, 1, 32'h0300_0001, 32'h0000_FFFF, 32'h0000_FFFF, 5'd16, 0};

    reset   = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_sel   = 2'd0;
    i_first = 5'd0;
    i_last  = 5'd0;
    i_dwell = 16'd0;
    clearStats();

    // Outputs while held in reset
    repeat (3) @(negedge clk);
    checkOutput("reset ctrl outputs",
                {25'd0, o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_step_valid, o_error}, 32'd0);
    checkOutput("reset addr", o_wb_addr, 32'd0);
    checkOutput("reset data", o_wb_data, 32'd0);
    checkOutput("reset step", {27'd0, o_step}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven sweeps against a zero-wait slave
    for (int k = 0; k < 5; k++) begin
      clearStats();
      ack_same  = vecs[k].ack_same;
      ack_delay = 1;
      never_ack = 1'b0;
      applyStimulus($sformatf("vec%0d", k), vecs[k].sel, vecs[k].first,
                    vecs[k].last, vecs[k].dwell);
      checkOutput($sformatf("vec%0d writes", k), wr_data.size(), vecs[k].writes);
      checkOutput($sformatf("vec%0d addr", k), lastAddr(), vecs[k].addr);
      checkOutput($sformatf("vec%0d first data", k), firstData(), vecs[k].data_first);
      checkOutput($sformatf("vec%0d last data", k), lastData(), vecs[k].data_last);
      checkOutput($sformatf("vec%0d final step", k), {27'd0, o_step}, {27'd0, vecs[k].step});
      checkOutput($sformatf("vec%0d step_valid count", k), sv_cnt, vecs[k].writes);
      checkOutput($sformatf("vec%0d done count", k), done_cnt, 1);
      checkOutput($sformatf("vec%0d protocol", k), proto_err, 0);
      checkOutput($sformatf("vec%0d error", k), {31'd0, o_error}, 32'd0);
      if (vecs[k].gap != 0) begin
        checkOutput($sformatf("vec%0d min gap", k), min_gap, vecs[k].gap);
        checkOutput($sformatf("vec%0d max gap", k), max_gap, vecs[k].gap);
      end
    end
    ack_same = 1'b0;

    // Slave stalls the first request for 3 cycles
    clearStats();
    stall_left = 3;
    applyStimulus("stall", 2'd1, 5'd0, 5'd1, 16'd0);
    checkOutput("stall stb cycles", stb_cycles, 5);
    checkOutput("stall stability", unstable, 0);
    checkOutput("stall writes", wr_data.size(), 2);
    checkOutput("stall last data", lastData(), 32'hFFFE_0001);
    checkOutput("stall done", done_cnt, 1);

    // Slave never acks: timeout after 15 WACK cycles
    clearStats();
    never_ack = 1'b1;
    applyStimulus("timeout", 2'd2, 5'd0, 5'd3, 16'd0);
    checkOutput("timeout wack cycles", wack_cycles, 15);
    checkOutput("timeout error", {31'd0, o_error}, 32'd1);
    checkOutput("timeout done", done_cnt, 0);
    checkOutput("timeout step_valid", sv_cnt, 0);
    checkOutput("timeout writes", wr_data.size(), 1);
    never_ack = 1'b0;
    clearStats();
    startSweep(2'd2, 5'd0, 5'd0, 16'd0);
    checkOutput("restart clears error", {31'd0, o_error}, 32'd0);
    waitIdle("restart");
    checkOutput("restart done", done_cnt, 1);

    // Abort while dwelling on step 1
    clearStats();
    startSweep(2'd1, 5'd0, 5'd5, 16'd10);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_step_valid && o_step == 5'd1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort dwell reached step 1", {31'd0, found}, 32'd1);
    i_abort = 1'b1;
    @(negedge clk);
    checkOutput("abort dwell busy", {31'd0, o_busy}, 32'd0);
    i_abort = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort dwell writes", wr_data.size(), 2);
    checkOutput("abort dwell stb cycles", stb_cycles, 2);
    checkOutput("abort dwell done", done_cnt, 0);
    checkOutput("abort dwell step", {27'd0, o_step}, 32'd1);

    // Abort during WACK: the late ack is still honoured
    clearStats();
    ack_delay = 4;
    startSweep(2'd1, 5'd0, 5'd5, 16'd0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_wb_cyc && !o_wb_stb) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort wack reached", {31'd0, found}, 32'd1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    waitIdle("abort wack");
    repeat (10) @(negedge clk);
    checkOutput("abort wack cyc held until ack", wack_cycles, 4);
    checkOutput("abort wack step_valid", sv_cnt, 0);
    checkOutput("abort wack done", done_cnt, 0);
    checkOutput("abort wack writes", wr_data.size(), 1);
    ack_delay = 1;

    // Reset while a stalled request is on the bus
    clearStats();
    stall_left = 50;
    startSweep(2'd2, 5'd3, 5'd4, 16'd0);
    @(negedge clk);
    checkOutput("pre-reset stb", {31'd0, o_wb_stb}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset ctrl outputs",
                {25'd0, o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_step_valid, o_error}, 32'd0);
    checkOutput("async reset addr", o_wb_addr, 32'd0);
    checkOutput("async reset data", o_wb_data, 32'd0);
    checkOutput("async reset step", {27'd0, o_step}, 32'd0);
    stall_left = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clearStats();
    applyStimulus("post-reset", 2'd1, 5'd1, 5'd2, 16'd1);
    checkOutput("post-reset writes", wr_data.size(), 2);
    checkOutput("post-reset last data", lastData(), 32'hFFFC_0003);
    checkOutput("post-reset done", done_cnt, 1);

    // Start while busy and start during the DONE cycle are both ignored
    clearStats();
    startSweep(2'd1, 5'd0, 5'd1, 16'd5);
    repeat (4) @(negedge clk);
    i_sel   = 2'd3;
    i_first = 5'd9;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_done) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("busy start done seen", {31'd0, found}, 32'd1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("start in done ignored", {31'd0, o_busy}, 32'd0);
    checkOutput("busy start writes", wr_data.size(), 2);
    checkOutput("busy start addr", lastAddr(), 32'h0300_0001);
    checkOutput("busy start final step", {27'd0, o_step}, 32'd1);
    checkOutput("busy start protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
